vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator replacing the fixed 640x480 controller and its external clock toggle.
- Derives the pixel enable from the system clock with a programmable divider.
- Generates hSync/vSync with configurable porch, pulse and polarity.
- Exposes active-area pixel coordinates and 2^TILE_SHIFT-square tile coordinates for the glyph fetch path.
- Delays sync/bright by a programmable number of pixel ticks so they line up with the downstream memory and glyph pipeline.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hSync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vSync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
CLK_DIV, 2, system clocks per pixel (>=1)
HSYNC_POL, 0, asserted level of hSync (0 = active low)
VSYNC_POL, 0, asserted level of vSync (0 = active low)
TILE_SHIFT, 4, log2 of tile edge in pixels
PIPE_DELAY, 2, pixel ticks of delay on hSync/vSync/bright (0..8)
CW, 10, coordinate width; must hold H_TOTAL-1 and V_TOTAL-1 (elaboration error otherwise)

Ports:
clk  in  1  system clock
clear  in  1  asynchronous active-high reset
en  in  1  run enable; 0 freezes the entire generator
pix_ce  out  1  one-clk pixel tick
hCount  out  CW  horizontal position, 0..H_TOTAL-1, 0 = first visible pixel
vCount  out  CW  vertical position, 0..V_TOTAL-1, 0 = first visible line
active  out  1  hCount<H_ACTIVE && vCount<V_ACTIVE; undelayed
tile_col  out  CW-TILE_SHIFT  hCount>>TILE_SHIFT
tile_row  out  CW-TILE_SHIFT  vCount>>TILE_SHIFT
tile_px  out  TILE_SHIFT  hCount[TILE_SHIFT-1:0]
tile_py  out  TILE_SHIFT  vCount[TILE_SHIFT-1:0]
hSync  out  1  delayed horizontal sync
vSync  out  1  delayed vertical sync
bright  out  1  delayed active
line_start  out  1  one-clk pulse
frame_start  out  1  one-clk pulse
vblank  out  1  vCount>=V_ACTIVE; undelayed

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
- Line order: active, front porch, sync, back porch.
- Horizontal sync region: H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC (656..751).
- Vertical sync region defined the same way (490..491).
- Reset (clear=1, async): divider=0, hCount=0, vCount=0, pix_ce=0, line_start=0, frame_start=0.
  - hSync=~HSYNC_POL, vSync=~VSYNC_POL, bright=0.
  - All delay-pipeline stages load the inactive values above.
- Divider counts 0..CLK_DIV-1 while en=1. pix_ce is registered and high for the one clk after the divider reaches CLK_DIV-1.
  - CLK_DIV=1: pix_ce high on every clk while en=1, starting the first clk after reset release.
- Counter update on a clk with pix_ce=1:
  - hCount==H_TOTAL-1: hCount wraps to 0, and vCount increments, wrapping to 0 when it equals V_TOTAL-1.
  - Otherwise hCount increments by 1.
- Derived outputs: active, vblank, tile_* are combinational from the counter registers. tile_* are computed outside the active area too; consumers qualify them with active.
- Delay pipeline: raw hs/vs/active are shifted through PIPE_DELAY stages that advance only on pix_ce.
  - PIPE_DELAY=0: outputs equal the raw decode of the current counters.
  - Sync outputs drive the POL level when inside their region.
- Pulses:
  - line_start = pix_ce && hCount==0.
  - frame_start = pix_ce && hCount==0 && vCount==0.
  - The first pix_ce after reset produces both.
- en=0: divider, counters, pix_ce (forced 0) and pipeline all hold; outputs stay static. Raising en resumes exactly where it stopped.
- Reset mid-frame: immediate return to reset state; the next frame starts from (0,0) with no partial sync pulse.

Test Plan:
- Defaults, release clear, run 2 frames: first frame_start at clk 2. Frame period = 800*525*2 = 840000 clks. line_start period = 1600 clks.
- Defaults: hSync=0 exactly while the undelayed hCount is 658..753, i.e. 96 pixel ticks per line. vSync=0 for 2 lines covering lines 490..491, offset by the 2-tick delay. bright=1 for 640 ticks per active line, 480 lines.
- Tile check: at hCount=639, vCount=479, expect tile_col=39, tile_row=29, tile_px=15, tile_py=15, active=1. At hCount=640, expect active=0.
- Small config (H 8/2/2/2, V 4/1/1/1, CLK_DIV=1, PIPE_DELAY=0, HSYNC_POL=1): pix_ce constant 1, hSync=1 exactly at hCount 10..11, frame period 14*7 = 98 clks.
- Drop en for 37 clks at hCount=100: all outputs frozen. After en rises, hCount continues at 101 with no lost or duplicated tick.
- Assert clear for 1 clk at hCount=700, vCount=300 (mid hSync): hSync goes high asynchronously and counters read 0. Next frame_start occurs 2 clks after release.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-enable divider, h/v counters,
// tile coordinates and a pixel-tick delay line aligning sync/bright with the glyph pipeline.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int CLK_DIV    = 2,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int TILE_SHIFT = 4,
  parameter int PIPE_DELAY = 2,
  parameter int CW         = 10
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     en,
  output logic                     pix_ce,
  output logic [CW-1:0]            hCount,
  output logic [CW-1:0]            vCount,
  output logic                     active,
  output logic [CW-TILE_SHIFT-1:0] tile_col,
  output logic [CW-TILE_SHIFT-1:0] tile_row,
  output logic [TILE_SHIFT-1:0]    tile_px,
  output logic [TILE_SHIFT-1:0]    tile_py,
  output logic                     hSync,
  output logic                     vSync,
  output logic                     bright,
  output logic                     line_start,
  output logic                     frame_start,
  output logic                     vblank
);

  localparam int H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_LO = H_ACTIVE + H_FRONT;
  localparam int H_SYNC_HI = H_SYNC_LO + H_SYNC;
  localparam int V_SYNC_LO = V_ACTIVE + V_FRONT;
  localparam int V_SYNC_HI = V_SYNC_LO + V_SYNC;
  localparam int DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic HS_ON   = (HSYNC_POL != 0);
  localparam logic VS_ON   = (VSYNC_POL != 0);

  generate
    if ((H_TOTAL - 1) >= (1 << CW) || (V_TOTAL - 1) >= (1 << CW)) begin : g_cw_check
      $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end
    if (CLK_DIV < 1 || PIPE_DELAY < 0 || PIPE_DELAY > 8) begin : g_param_check
      $error("vga_timing_gen: CLK_DIV or PIPE_DELAY out of range");
    end
  endgenerate

  logic [DW-1:0] div_q, div_d;
  logic          pix_ce_q, pix_ce_d;
  logic [CW-1:0] hcount_q, hcount_d;
  logic [CW-1:0] vcount_q, vcount_d;
  logic          tick;
  logic          hs_raw, vs_raw, active_raw;

  // A pending pix_ce_q survives en=0, so resuming replays exactly the tick that was due.
  assign tick = pix_ce_q & en;

  always_comb begin
    div_d    = div_q;
    pix_ce_d = pix_ce_q;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (en) begin
      pix_ce_d = (div_q == DW'(CLK_DIV - 1));
      div_d    = (div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + DW'(1);
    end
    if (tick) begin
      if (hcount_q == CW'(H_TOTAL - 1)) begin
        hcount_d = '0;
        vcount_d = (vcount_q == CW'(V_TOTAL - 1)) ? '0 : vcount_q + CW'(1);
      end else begin
        hcount_d = hcount_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      div_q    <= '0;
      pix_ce_q <= 1'b0;
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      div_q    <= div_d;
      pix_ce_q <= pix_ce_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  always_comb begin
    hs_raw     = (hcount_q >= CW'(H_SYNC_LO) && hcount_q < CW'(H_SYNC_HI)) ? HS_ON : ~HS_ON;
    vs_raw     = (vcount_q >= CW'(V_SYNC_LO) && vcount_q < CW'(V_SYNC_HI)) ? VS_ON : ~VS_ON;
    active_raw = (hcount_q < CW'(H_ACTIVE)) && (vcount_q < CW'(V_ACTIVE));
  end

  assign pix_ce      = tick;
  assign hCount      = hcount_q;
  assign vCount      = vcount_q;
  assign active      = active_raw;
  assign vblank      = (vcount_q >= CW'(V_ACTIVE));
  assign tile_col    = hcount_q[CW-1:TILE_SHIFT];
  assign tile_row    = vcount_q[CW-1:TILE_SHIFT];
  assign tile_px     = hcount_q[TILE_SHIFT-1:0];
  assign tile_py     = vcount_q[TILE_SHIFT-1:0];
  assign line_start  = tick && (hcount_q == '0);
  assign frame_start = line_start && (vcount_q == '0);

  generate
    if (PIPE_DELAY == 0) begin : g_nodelay
      assign hSync  = hs_raw;
      assign vSync  = vs_raw;
      assign bright = active_raw;
    end else begin : g_delay
      logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
      logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;
      logic [PIPE_DELAY-1:0] br_pipe_q, br_pipe_d;

      // Bit 0 takes the current decode; the oldest sample sits in the top bit.
      always_comb begin
        hs_pipe_d = hs_pipe_q;
        vs_pipe_d = vs_pipe_q;
        br_pipe_d = br_pipe_q;
        if (tick) begin
          hs_pipe_d = PIPE_DELAY'({hs_pipe_q, hs_raw});
          vs_pipe_d = PIPE_DELAY'({vs_pipe_q, vs_raw});
          br_pipe_d = PIPE_DELAY'({br_pipe_q, active_raw});
        end
      end

      always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
          hs_pipe_q <= {PIPE_DELAY{~HS_ON}};
          vs_pipe_q <= {PIPE_DELAY{~VS_ON}};
          br_pipe_q <= '0;
        end else begin
          hs_pipe_q <= hs_pipe_d;
          vs_pipe_q <= vs_pipe_d;
          br_pipe_q <= br_pipe_d;
        end
      end

      assign hSync  = hs_pipe_q[PIPE_DELAY-1];
      assign vSync  = vs_pipe_q[PIPE_DELAY-1];
      assign bright = br_pipe_q[PIPE_DELAY-1];
    end
  endgenerate

endmodule
